data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage load/store port.
- Accepts one word request at a time over a valid/ready handshake and returns read data or write completion after a fixed, parameterised latency.
- Drives a stall line that the pipeline uses to freeze its earlier stages while an access is outstanding.
- Flags misaligned and out-of-range addresses instead of touching storage.

---
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory behind the MEM-stage load/store port.
// One request in flight; response after LATENCY edges; bad addresses flagged, storage untouched.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        stall
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            error_q;
    logic [31:0]     mem_q [DEPTH];

    logic            req_err;
    logic            accept;
    logic            do_access;

    assign req_err   = (req_addr[1:0] != 2'b00) | (req_addr[31:2] >= 30'(DEPTH));
    assign accept    = (state_q == StIdle) & req_valid;
    assign do_access = (state_q == StBusy) & (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StBusy;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are latched once so the pipeline may move on after acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            write_q <= req_write;
            err_q   <= req_err;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else if (do_access) begin
            rdata_q <= (!write_q && !err_q) ? mem_q[idx_q] : 32'd0;
            error_q <= err_q;
        end else if (state_q == StResp) begin
            error_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_access && write_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    // Low in RESP so the pipeline advances while resp_rdata is valid.
    assign stall      = ((state_q == StIdle) & req_valid) | (state_q == StBusy);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus multi-cycle corner sequences,
// with LATENCY=1 and LATENCY=15 instances alongside the default build.
module tb_data_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, v_alt;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_error, stall;
    logic [31:0] resp_rdata;
    logic        ready1, rv1, err1, stall1;
    logic [31:0] rdata1;
    logic        ready15, rv15, err15, stall15;
    logic [31:0] rdata15;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .stall(stall)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(v_alt), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready1),
        .resp_valid(rv1), .resp_rdata(rdata1), .resp_error(err1), .stall(stall1)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(15)) dut15 (
        .clock(clock), .reset(reset), .req_valid(v_alt), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready15),
        .resp_valid(rv15), .resp_rdata(rdata15), .resp_error(err15), .stall(stall15)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All sampling and driving happens 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input vec_t v);
        int n;
        chk({v.name, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1;
        chk({v.name, " stall_req"}, 32'(stall), 32'd1);
        tick();
        // Scramble inputs after acceptance; only captured values may matter.
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'hFFFF_FFFF;
        chk({v.name, " stall_busy0"}, 32'(stall), 32'd1);
        chk({v.name, " ready_busy0"}, 32'(req_ready), 32'd0);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (resp_valid) break;
            chk({v.name, " stall_busy"}, 32'(stall), 32'd1);
        end
        chk({v.name, " latency"}, 32'(n), 32'(LAT));
        chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
        chk({v.name, " error"}, 32'(resp_error), 32'(v.exp_err));
        chk({v.name, " stall_resp"}, 32'(stall), 32'd0);
        chk({v.name, " ready_resp"}, 32'(req_ready), 32'd0);
        tick();
        chk({v.name, " valid_drop"}, 32'(resp_valid), 32'd0);
        chk({v.name, " error_drop"}, 32'(resp_error), 32'd0);
        chk({v.name, " rdata_hold"}, resp_rdata, v.exp_rdata);
        chk({v.name, " ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        ow [4];
        logic [31:0] od [4];
        logic [31:0] exp_q [4];
        int k, nresp, last, n1, n15, busy15;
        logic seen;

        reset = 1'b1; req_valid = 1'b0; v_alt = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        vecs.push_back('{"sw10",  1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{"lw10",  1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"lw14",  1'b0, 32'h14,  32'h0,        32'h0,        1'b0});
        vecs.push_back('{"sw00",  1'b1, 32'h0,   32'hA5A50001, 32'h0,        1'b0});
        vecs.push_back('{"lw12",  1'b0, 32'h12,  32'h0,        32'h0,        1'b1});
        vecs.push_back('{"sw100", 1'b1, 32'h100, 32'h0000FFFF, 32'h0,        1'b1});
        vecs.push_back('{"lw00",  1'b0, 32'h0,   32'h0,        32'hA5A50001, 1'b0});
        vecs.push_back('{"swFC",  1'b1, 32'hFC,  32'h0BADF00D, 32'h0,        1'b0});
        vecs.push_back('{"lwFC",  1'b0, 32'hFC,  32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{"lw101", 1'b0, 32'h101, 32'h0,        32'h0,        1'b1});

        tick(); tick();
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst valid", 32'(resp_valid), 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst error", 32'(resp_error), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // req_valid held high, alternating sw/lw to 0x4.
        ow[0] = 1'b1; od[0] = 32'h11111111;
        ow[1] = 1'b0; od[1] = 32'h0;
        ow[2] = 1'b1; od[2] = 32'h22222222;
        ow[3] = 1'b0; od[3] = 32'h0;
        k = 0; nresp = 0; last = 0;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            if (resp_valid) begin
                chk("b2b rdata", resp_rdata, exp_q[nresp]);
                nresp++;
            end
            if (req_ready) begin
                if (k < 4) begin
                    if (k > 0) chk("b2b spacing", 32'(c - last), 32'(LAT + 2));
                    last = c;
                    req_valid = 1'b1;
                    req_write = ow[k];
                    req_addr  = 32'h4;
                    req_wdata = od[k];
                    exp_q[k]  = ow[k] ? 32'h0 : od[k-1];
                    k++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            tick();
        end
        req_valid = 1'b0;
        chk("b2b responses", 32'(nresp), 32'd4);
        tick(); tick();

        // LATENCY=1 and LATENCY=15 builds, lw 0x0.
        v_alt = 1'b1; req_write = 1'b0; req_addr = 32'h0;
        tick();
        v_alt = 1'b0;
        chk("lat1 stall_busy", 32'(stall1), 32'd1);
        busy15 = stall15 ? 1 : 0;
        n1 = 0; n15 = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (rv1 && n1 == 0) n1 = n;
            if (rv15 && n15 == 0) n15 = n;
            if (n15 == 0 && stall15) busy15++;
        end
        chk("lat1 latency", 32'(n1), 32'd1);
        chk("lat15 latency", 32'(n15), 32'd15);
        chk("lat15 stall_cycles", 32'(busy15), 32'd15);
        chk("lat1 rdata", rdata1, 32'd0);
        chk("lat15 error", 32'(err15), 32'd0);

        // Reset mid-BUSY drops the write and the response.
        chk("rb ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rb stall", 32'(stall), 32'd0);
        chk("rb ready_async", 32'(req_ready), 32'd1);
        tick(); tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        chk("rb no_resp", 32'(seen), 32'd0);
        do_req('{"rb lw08", 1'b0, 32'h8,  32'h0, 32'h0, 1'b0});
        do_req('{"rb lw10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
